// File: rtl/cpu_trace_checker_pkg.sv
// Shared types for the CPU trace checker: FSM states, probe channel indices, table entry layout.
// The entry layout gains a per-entry compare mask when CHECK_MASK_EN is defined.
package cpu_check_pkg;

   localparam int CHK_WIDTH    = 32;
   localparam int CHK_CHANNELS = 6;
   localparam int CHK_CW       = $clog2(CHK_CHANNELS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Probe bus channel order as wired from the single-cycle CPU
   localparam int CH_DMEM_RD = 0;
   localparam int CH_WDATA   = 1;
   localparam int CH_ADDRES  = 2;
   localparam int CH_RD1     = 3;
   localparam int CH_RD2     = 4;
   localparam int CH_ALURES  = 5;

   typedef struct packed {
      logic [CHK_CW-1:0]    chan;
      logic [CHK_WIDTH-1:0] exp;
`ifdef CHECK_MASK_EN
      logic [CHK_WIDTH-1:0] mask;
`endif
   } trace_entry_t;

endpackage

// File: rtl/cpu_trace_checker_trace_table.sv
// Expectation table: DEPTH entries with one write port and a combinational read port.
// Contents are deliberately not reset so a loaded table survives a checker reset.
module trace_table
   import cpu_check_pkg::*;
#(
   parameter int  DEPTH   = 32,
   parameter int  AW      = $clog2(DEPTH),
   parameter type entry_t = trace_entry_t
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);

   entry_t mem_q [DEPTH];
   entry_t mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_trace_checker.sv
// Self-checking scoreboard for the single-cycle CPU: compares one probe channel per retired
// instruction against a programmed table. Optional macro CHECK_MASK_EN adds per-entry masks.
module cpu_trace_checker #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int CHANNELS = 6,
   parameter int AW       = $clog2(DEPTH),
   parameter int CW       = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_we,
   input  logic [AW-1:0]             cfg_addr,
   input  logic [CW-1:0]             cfg_chan,
   input  logic [WIDTH-1:0]          cfg_exp,
`ifdef CHECK_MASK_EN
   input  logic [WIDTH-1:0]          cfg_mask,
`endif
   input  logic [AW:0]               num_checks,
   input  logic                      start,
   input  logic                      step,
   input  logic [CHANNELS*WIDTH-1:0] probe_bus,
   output logic                      busy,
   output logic                      endtest,
   output logic                      dutpassed,
   output logic [AW:0]               check_idx,
   output logic [AW:0]               fail_count,
   output logic [AW-1:0]             first_fail_idx,
   output logic [WIDTH-1:0]          first_fail_actual
);
   import cpu_check_pkg::*;

   typedef struct packed {
      logic [CW-1:0]    chan;
      logic [WIDTH-1:0] exp;
`ifdef CHECK_MASK_EN
      logic [WIDTH-1:0] mask;
`endif
   } entry_t;

   state_t            state_q, state_d;
   logic [AW:0]       num_q, num_d;
   logic [AW:0]       idx_q, idx_d;
   logic [AW:0]       fail_q, fail_d;
   logic [AW-1:0]     ffi_q, ffi_d;
   logic [WIDTH-1:0]  ffa_q, ffa_d;
   logic              endtest_q, endtest_d;
   logic              dutpassed_q, dutpassed_d;

   entry_t            wr_entry, rd_entry;
   logic              tbl_we;
   logic [WIDTH-1:0]  actual;
   logic [WIDTH-1:0]  diff;
   logic              chan_valid;
   logic              mismatch;

   always_comb begin
      wr_entry      = '0;
      wr_entry.chan = cfg_chan;
      wr_entry.exp  = cfg_exp;
`ifdef CHECK_MASK_EN
      wr_entry.mask = cfg_mask;
`endif
   end

   trace_table #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .entry_t (entry_t)
   ) u_table (
      .clk   (clk),
      .we    (tbl_we),
      .waddr (cfg_addr),
      .wdata (wr_entry),
      .raddr (idx_q[AW-1:0]),
      .rdata (rd_entry)
   );

   // An out-of-range channel select reads as zero and is forced to mismatch
   always_comb begin
      actual     = '0;
      chan_valid = (int'(rd_entry.chan) < CHANNELS);
      for (int k = 0; k < CHANNELS; k++) begin
         if (int'(rd_entry.chan) == k) begin
            actual = probe_bus[k*WIDTH +: WIDTH];
         end
      end
      diff = actual ^ rd_entry.exp;
`ifdef CHECK_MASK_EN
      diff = diff & rd_entry.mask;
`endif
      mismatch = !chan_valid || (diff != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         num_q       <= '0;
         idx_q       <= '0;
         fail_q      <= '0;
         ffi_q       <= '0;
         ffa_q       <= '0;
         endtest_q   <= 1'b0;
         dutpassed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         idx_q       <= idx_d;
         fail_q      <= fail_d;
         ffi_q       <= ffi_d;
         ffa_q       <= ffa_d;
         endtest_q   <= endtest_d;
         dutpassed_q <= dutpassed_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      idx_d       = idx_q;
      fail_d      = fail_q;
      ffi_d       = ffi_q;
      ffa_d       = ffa_q;
      endtest_d   = endtest_q;
      dutpassed_d = dutpassed_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               num_d  = num_checks;
               idx_d  = '0;
               fail_d = '0;
               ffi_d  = '0;
               ffa_d  = '0;
               if (num_checks == '0) begin
                  state_d     = DONE;
                  endtest_d   = 1'b1;
                  dutpassed_d = 1'b1;
               end else begin
                  state_d     = RUN;
                  endtest_d   = 1'b0;
                  dutpassed_d = 1'b0;
               end
            end
         end
         RUN: begin
            if (step) begin
               idx_d = idx_q + (AW+1)'(1);
               if (mismatch) begin
                  fail_d = fail_q + (AW+1)'(1);
                  if (fail_q == '0) begin
                     ffi_d = idx_q[AW-1:0];
                     ffa_d = actual;
                  end
               end
               // Verdict includes the compare made on this final step
               if (idx_q == num_q - (AW+1)'(1)) begin
                  state_d     = DONE;
                  endtest_d   = 1'b1;
                  dutpassed_d = (fail_d == '0);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy              = (state_q == RUN);
      tbl_we            = cfg_we && (state_q != RUN);
      endtest           = endtest_q;
      dutpassed         = dutpassed_q;
      check_idx         = idx_q;
      fail_count        = fail_q;
      first_fail_idx    = ffi_q;
      first_fail_actual = ffa_q;
   end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed self-checking bench for cpu_trace_checker; mask scenario only when CHECK_MASK_EN is defined.
module tb_cpu_trace_checker;
   import cpu_check_pkg::*;

   localparam int WIDTH    = 32;
   localparam int DEPTH    = 32;
   localparam int CHANNELS = 6;
   localparam int AW       = 5;
   localparam int CW       = 3;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      cfg_we;
   logic [AW-1:0]             cfg_addr;
   logic [CW-1:0]             cfg_chan;
   logic [WIDTH-1:0]          cfg_exp;
   logic [WIDTH-1:0]          cfg_mask;
   logic [AW:0]               num_checks;
   logic                      start;
   logic                      step;
   logic [CHANNELS*WIDTH-1:0] probe_bus;
   logic                      busy;
   logic                      endtest;
   logic                      dutpassed;
   logic [AW:0]               check_idx;
   logic [AW:0]               fail_count;
   logic [AW-1:0]             first_fail_idx;
   logic [WIDTH-1:0]          first_fail_actual;

   int vectors = 0;
   int miscompares = 0;

   cpu_trace_checker #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cfg_we            (cfg_we),
      .cfg_addr          (cfg_addr),
      .cfg_chan          (cfg_chan),
      .cfg_exp           (cfg_exp),
`ifdef CHECK_MASK_EN
      .cfg_mask          (cfg_mask),
`endif
      .num_checks        (num_checks),
      .start             (start),
      .step              (step),
      .probe_bus         (probe_bus),
      .busy              (busy),
      .endtest           (endtest),
      .dutpassed         (dutpassed),
      .check_idx         (check_idx),
      .fail_count        (fail_count),
      .first_fail_idx    (first_fail_idx),
      .first_fail_actual (first_fail_actual)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CHANNELS*WIDTH-1:0] make_probe(input int ch, input logic [WIDTH-1:0] val);
      logic [CHANNELS*WIDTH-1:0] bus;
      for (int k = 0; k < CHANNELS; k++) begin
         bus[k*WIDTH +: WIDTH] = 32'hA5A5_0000 + k;
      end
      bus[ch*WIDTH +: WIDTH] = val;
      return bus;
   endfunction

   task automatic load_entry(input int addr, input logic [CW-1:0] ch,
                             input logic [WIDTH-1:0] exp, input logic [WIDTH-1:0] mask);
      cfg_we   = 1'b1;
      cfg_addr = AW'(addr);
      cfg_chan = ch;
      cfg_exp  = exp;
      cfg_mask = mask;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic start_run(input int n);
      num_checks = (AW+1)'(n);
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic do_step(input int ch, input logic [WIDTH-1:0] val);
      step      = 1'b1;
      probe_bus = make_probe(ch, val);
      tick();
      step      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
      vectors++; if (endtest !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_endtest: got %0h expected 0", endtest); end
      vectors++; if (dutpassed !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dutpassed: got %0h expected 0", dutpassed); end
      vectors++; if (check_idx !== '0) begin miscompares++; $display("[TB] FAIL reset_check_idx: got %0h expected 0", check_idx); end
      vectors++; if (fail_count !== '0) begin miscompares++; $display("[TB] FAIL reset_fail_count: got %0h expected 0", fail_count); end
      vectors++; if (first_fail_idx !== '0) begin miscompares++; $display("[TB] FAIL reset_ff_idx: got %0h expected 0", first_fail_idx); end
      vectors++; if (first_fail_actual !== '0) begin miscompares++; $display("[TB] FAIL reset_ff_actual: got %0h expected 0", first_fail_actual); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_pass();
      load_entry(0, CW'(CH_WDATA), 32'h3FFC, 32'hFFFF_FFFF);
      load_entry(1, CW'(CH_WDATA), 32'h0004, 32'hFFFF_FFFF);
      start_run(2);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL pass_busy: got %0h expected 1", busy); end
      vectors++; if (endtest !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_endtest_early: got %0h expected 0", endtest); end
      do_step(CH_WDATA, 32'h3FFC);
      vectors++; if (check_idx !== 6'd1) begin miscompares++; $display("[TB] FAIL pass_idx1: got %0h expected 1", check_idx); end
      vectors++; if (endtest !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_endtest_mid: got %0h expected 0", endtest); end
      do_step(CH_WDATA, 32'h0004);
      vectors++; if (endtest !== 1'b1) begin miscompares++; $display("[TB] FAIL pass_endtest: got %0h expected 1", endtest); end
      vectors++; if (dutpassed !== 1'b1) begin miscompares++; $display("[TB] FAIL pass_dutpassed: got %0h expected 1", dutpassed); end
      vectors++; if (fail_count !== 6'd0) begin miscompares++; $display("[TB] FAIL pass_fail_count: got %0h expected 0", fail_count); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_busy_done: got %0h expected 0", busy); end
      vectors++; if (check_idx !== 6'd2) begin miscompares++; $display("[TB] FAIL pass_idx2: got %0h expected 2", check_idx); end
   endtask

   task automatic test_mismatch();
      start_run(2);
      vectors++; if (endtest !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_endtest_clear: got %0h expected 0", endtest); end
      do_step(CH_WDATA, 32'h3FFC);
      do_step(CH_WDATA, 32'h0005);
      vectors++; if (endtest !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_endtest: got %0h expected 1", endtest); end
      vectors++; if (dutpassed !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_dutpassed: got %0h expected 0", dutpassed); end
      vectors++; if (fail_count !== 6'd1) begin miscompares++; $display("[TB] FAIL mis_fail_count: got %0h expected 1", fail_count); end
      vectors++; if (first_fail_idx !== 5'd1) begin miscompares++; $display("[TB] FAIL mis_ff_idx: got %0h expected 1", first_fail_idx); end
      vectors++; if (first_fail_actual !== 32'h5) begin miscompares++; $display("[TB] FAIL mis_ff_actual: got %0h expected 5", first_fail_actual); end
   endtask

   task automatic test_zero_checks();
      start_run(0);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy: got %0h expected 0", busy); end
      vectors++; if (endtest !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_endtest: got %0h expected 1", endtest); end
      vectors++; if (dutpassed !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_dutpassed: got %0h expected 1", dutpassed); end
      vectors++; if (fail_count !== 6'd0) begin miscompares++; $display("[TB] FAIL zero_fail_count: got %0h expected 0", fail_count); end
      tick();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy_later: got %0h expected 0", busy); end
   endtask

   task automatic test_invalid_chan();
      load_entry(0, CW'(CH_ADDRES), 32'h0001_4098, 32'hFFFF_FFFF);
      load_entry(1, 3'd6, 32'h0, 32'hFFFF_FFFF);
      start_run(2);
      do_step(CH_ADDRES, 32'h0001_4098);
      do_step(CH_ADDRES, 32'h0);
      vectors++; if (fail_count !== 6'd1) begin miscompares++; $display("[TB] FAIL inv_fail_count: got %0h expected 1", fail_count); end
      vectors++; if (first_fail_idx !== 5'd1) begin miscompares++; $display("[TB] FAIL inv_ff_idx: got %0h expected 1", first_fail_idx); end
      vectors++; if (dutpassed !== 1'b0) begin miscompares++; $display("[TB] FAIL inv_dutpassed: got %0h expected 0", dutpassed); end
      do_step(CH_ADDRES, 32'h0);
      vectors++; if (check_idx !== 6'd2) begin miscompares++; $display("[TB] FAIL inv_step_after_done_idx: got %0h expected 2", check_idx); end
      vectors++; if (fail_count !== 6'd1) begin miscompares++; $display("[TB] FAIL inv_step_after_done_fc: got %0h expected 1", fail_count); end
      start_run(2);
      do_step(CH_ADDRES, 32'h0001_4099);
      do_step(CH_ADDRES, 32'h0);
      vectors++; if (fail_count !== 6'd2) begin miscompares++; $display("[TB] FAIL inv2_fail_count: got %0h expected 2", fail_count); end
      vectors++; if (first_fail_idx !== 5'd0) begin miscompares++; $display("[TB] FAIL inv2_ff_idx: got %0h expected 0", first_fail_idx); end
      vectors++; if (first_fail_actual !== 32'h0001_4099) begin miscompares++; $display("[TB] FAIL inv2_ff_actual: got %0h expected 14099", first_fail_actual); end
   endtask

   task automatic test_midrun_reset();
      load_entry(0, CW'(CH_ALURES), 32'h10, 32'hFFFF_FFFF);
      load_entry(1, CW'(CH_ALURES), 32'h20, 32'hFFFF_FFFF);
      load_entry(2, CW'(CH_ALURES), 32'h30, 32'hFFFF_FFFF);
      start_run(3);
      load_entry(1, CW'(CH_ALURES), 32'hDEAD, 32'hFFFF_FFFF);
      do_step(CH_ALURES, 32'h10);
      vectors++; if (check_idx !== 6'd1) begin miscompares++; $display("[TB] FAIL mid_idx1: got %0h expected 1", check_idx); end
      rst_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_busy: got %0h expected 0", busy); end
      vectors++; if (check_idx !== '0) begin miscompares++; $display("[TB] FAIL mid_rst_idx: got %0h expected 0", check_idx); end
      vectors++; if (endtest !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_endtest: got %0h expected 0", endtest); end
      vectors++; if (dutpassed !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_dutpassed: got %0h expected 0", dutpassed); end
      tick();
      rst_n = 1'b1;
      tick();
      start_run(3);
      do_step(CH_ALURES, 32'h10);
      do_step(CH_ALURES, 32'h20);
      do_step(CH_ALURES, 32'h30);
      vectors++; if (endtest !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rerun_endtest: got %0h expected 1", endtest); end
      vectors++; if (dutpassed !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rerun_dutpassed: got %0h expected 1", dutpassed); end
      vectors++; if (fail_count !== 6'd0) begin miscompares++; $display("[TB] FAIL mid_rerun_fail_count: got %0h expected 0", fail_count); end
   endtask

`ifdef CHECK_MASK_EN
   task automatic test_mask();
      load_entry(0, CW'(CH_RD1), 32'h3FF8, 32'hFFF0);
      start_run(1);
      do_step(CH_RD1, 32'h3FF4);
      vectors++; if (dutpassed !== 1'b1) begin miscompares++; $display("[TB] FAIL mask_pass: got %0h expected 1", dutpassed); end
      load_entry(0, CW'(CH_RD1), 32'h3FF8, 32'hFFFF);
      start_run(1);
      do_step(CH_RD1, 32'h3FF4);
      vectors++; if (dutpassed !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_fail: got %0h expected 0", dutpassed); end
      vectors++; if (first_fail_actual !== 32'h3FF4) begin miscompares++; $display("[TB] FAIL mask_ff_actual: got %0h expected 3ff4", first_fail_actual); end
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      cfg_we     = 1'b0;
      cfg_addr   = '0;
      cfg_chan   = '0;
      cfg_exp    = '0;
      cfg_mask   = '0;
      num_checks = '0;
      start      = 1'b0;
      step       = 1'b0;
      probe_bus  = '0;
      test_reset();
      test_pass();
      test_mismatch();
      test_zero_checks();
      test_invalid_chan();
      test_midrun_reset();
`ifdef CHECK_MASK_EN
      test_mask();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
